// File: rtl/frame_rx.sv
// frame_rx: parses [SOF][LEN][payload][CSUM] frames from a valid/ready byte
// stream. Payload bytes are written speculatively into a commit/rollback FIFO
// and become visible to the sink only once the frame's XOR checksum matches.
// Frames with a bad checksum are rolled back whole.
module frame_rx #(
   parameter int         DEPTH   = 16,
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] SOF     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic [7:0] payload,
   output logic       payload_valid,
   input  logic       payload_ready,
   output logic       payload_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_LEN  = 2'd1,
      ST_PAY  = 2'd2,
      ST_CSUM = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [PW-1:0]   swptr_q, swptr_d;
   logic [PW-1:0]   cwptr_q, cwptr_d;
   logic [7:0]      rem_q, rem_d;
   logic [7:0]      acc_q, acc_d;
   logic            frame_ok_q, frame_ok_d;
   logic            frame_err_q, frame_err_d;
   logic [1:0]      err_code_q, err_code_d;

   logic [8:0]      mem_q [DEPTH];
   logic            mem_we_s;
   logic [8:0]      mem_wdata_s;
   logic [8:0]      head_s;

   logic [PW-1:0]   free_s;
   logic            len_bad_s;
   logic            fits_s;
   logic            accept_s;
   logic            pop_s;

   // Space left for a new frame; uses the pre-pop read pointer, so a pop in
   // the same cycle is ignored and the LEN check stays conservative.
   assign free_s    = PW'(DEPTH) - (swptr_q - rptr_q);
   assign len_bad_s = (data_in == 8'd0) || (data_in > 8'(MAX_LEN));
   assign fits_s    = (9'(free_s) >= {1'b0, data_in});

   assign head_s        = mem_q[rptr_q[AW-1:0]];
   assign payload_valid = (rptr_q != cwptr_q);
   assign payload       = payload_valid ? head_s[7:0] : 8'd0;
   assign payload_last  = payload_valid ? head_s[8] : 1'b0;
   assign pop_s         = payload_valid & payload_ready;
   assign accept_s      = valid_in & ready_out;

   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

   // Input readiness: only LEN can stall, and only for a legal length that
   // does not fit; illegal lengths are always accepted so they can be rejected.
   always_comb begin
      ready_out = 1'b1;
      case (state_q)
         ST_LEN:  ready_out = len_bad_s | fits_s;
         default: ready_out = 1'b1;
      endcase
   end

   // Next-state logic: frame parser, speculative write/commit/rollback, read side.
   always_comb begin
      state_d     = state_q;
      swptr_d     = swptr_q;
      cwptr_d     = cwptr_q;
      rem_d       = rem_q;
      acc_d       = acc_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = 2'd0;
      mem_we_s    = 1'b0;
      mem_wdata_s = 9'd0;

      if (pop_s) begin
         rptr_d = rptr_q + PW'(1);
      end else begin
         rptr_d = rptr_q;
      end

      if (accept_s) begin
         case (state_q)
            ST_HUNT: begin
               if (data_in == SOF) begin
                  state_d = ST_LEN;
               end else begin
                  state_d = ST_HUNT;
               end
            end
            ST_LEN: begin
               if (len_bad_s) begin
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd1;
                  state_d     = ST_HUNT;
               end else begin
                  rem_d   = data_in;
                  acc_d   = 8'd0;
                  state_d = ST_PAY;
               end
            end
            ST_PAY: begin
               mem_we_s    = 1'b1;
               mem_wdata_s = {(rem_q == 8'd1), data_in};
               swptr_d     = swptr_q + PW'(1);
               acc_d       = acc_q ^ data_in;
               rem_d       = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_PAY;
               end
            end
            ST_CSUM: begin
               if (data_in == acc_q) begin
                  cwptr_d    = swptr_q;
                  frame_ok_d = 1'b1;
               end else begin
                  swptr_d     = cwptr_q;
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd2;
               end
               state_d = ST_HUNT;
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HUNT;
         rptr_q      <= '0;
         swptr_q     <= '0;
         cwptr_q     <= '0;
         rem_q       <= 8'd0;
         acc_q       <= 8'd0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         rptr_q      <= rptr_d;
         swptr_q     <= swptr_d;
         cwptr_q     <= cwptr_d;
         rem_q       <= rem_d;
         acc_q       <= acc_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   // Payload storage; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[swptr_q[AW-1:0]] <= mem_wdata_s;
      end
   end

endmodule

// File: tb/tb_frame_rx.sv
// Scoreboard bench for frame_rx: stimulus pushes expected payload bytes and
// frame events into queues; a negedge monitor pops and compares them.
module tb_frame_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic [7:0] payload;
   logic       payload_valid;
   logic       payload_ready;
   logic       payload_last;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   // event encoding {ok, err, code[1:0]}
   localparam logic [3:0] EV_OK  = 4'b1000;
   localparam logic [3:0] EV_LEN = 4'b0101;
   localparam logic [3:0] EV_CS  = 4'b0110;

   logic [8:0] exp_pay [$];
   logic [3:0] exp_evt [$];
   int total = 0;
   int bad   = 0;

   frame_rx dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .payload       (payload),
      .payload_valid (payload_valid),
      .payload_ready (payload_ready),
      .payload_last  (payload_last),
      .frame_ok      (frame_ok),
      .frame_err     (frame_err),
      .err_code      (err_code)
   );

   always #5 clk = ~clk;

   // Monitor: compare DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      logic [3:0] e;
      logic [8:0] p;
      if (!rst) begin
         total++;
         if (frame_ok || frame_err) begin
            if (exp_evt.size() == 0) begin
               bad++;
               $display("FAIL evt_unexpected: got ok=%b err=%b code=%0d, expected none",
                        frame_ok, frame_err, err_code);
            end else begin
               e = exp_evt.pop_front();
               if ({frame_ok, frame_err, err_code} !== e) begin
                  bad++;
                  $display("FAIL evt: got %b, expected %b", {frame_ok, frame_err, err_code}, e);
               end
            end
         end else if (err_code !== 2'd0) begin
            bad++;
            $display("FAIL err_code_idle: got %0d, expected 0", err_code);
         end
         if (payload_valid && payload_ready) begin
            total++;
            if (exp_pay.size() == 0) begin
               bad++;
               $display("FAIL pay_unexpected: got %h last=%b, expected none", payload, payload_last);
            end else begin
               p = exp_pay.pop_front();
               if ({payload_last, payload} !== p) begin
                  bad++;
                  $display("FAIL pay: got last=%b byte=%h, expected last=%b byte=%h",
                           payload_last, payload, p[8], p[7:0]);
               end
            end
         end
         if (!payload_valid) begin
            total++;
            if ({payload_last, payload} !== 9'd0) begin
               bad++;
               $display("FAIL empty_out: got %h, expected 0", {payload_last, payload});
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      data_in  = b;
      valid_in = 1'b1;
      @(negedge clk);
      while (!ready_out && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!ready_out) begin
         bad++;
         $display("FAIL send_timeout: byte %h never accepted, got ready=0 expected 1", b);
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      data_in  = 8'd0;
   endtask

   task automatic send_frame(input logic [7:0] pl [$], input logic [7:0] cs, input logic [3:0] ev);
      if (ev == EV_OK) begin
         for (int i = 0; i < pl.size(); i++)
            exp_pay.push_back({(i == pl.size() - 1), pl[i]});
      end
      exp_evt.push_back(ev);
      send(8'hA5);
      send(8'(pl.size()));
      for (int i = 0; i < pl.size(); i++) send(pl[i]);
      send(cs);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_pay.size() != 0 || exp_evt.size() != 0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (exp_pay.size() != 0 || exp_evt.size() != 0) begin
         bad++;
         $display("FAIL %s_drain: got pay=%0d evt=%0d pending, expected 0",
                  name, exp_pay.size(), exp_evt.size());
      end
   endtask

   task automatic pop_one();
      payload_ready = 1'b1;
      @(posedge clk);
      #1;
      payload_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] pl [$];
      rst = 1'b1;
      data_in = 8'd0;
      valid_in = 1'b0;
      payload_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", {6'd0, payload_valid, payload_last, payload}, 16'd0);
      check("reset_flags", {12'd0, frame_ok, frame_err, err_code}, 16'd0);
      check("reset_ready", {15'd0, ready_out}, 16'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: good frame
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(pl, 8'h00, EV_OK);
      wait_drain("t1");

      // 2: bad checksum, then a good one-byte frame
      pl = '{8'h10, 8'h20};
      send_frame(pl, 8'hFF, EV_CS);
      wait_drain("t2a");
      @(negedge clk);
      check("t2_no_payload", {15'd0, payload_valid}, 16'd0);
      @(posedge clk);
      #1;
      pl = '{8'h5A};
      send_frame(pl, 8'h5A, EV_OK);
      wait_drain("t2b");

      // 3: resync over junk
      send(8'h00);
      send(8'hFF);
      send(8'h3C);
      pl = '{8'h7E};
      send_frame(pl, 8'h7E, EV_OK);
      wait_drain("t3");

      // 4: bad LEN values, then a stray byte in HUNT
      exp_evt.push_back(EV_LEN);
      send(8'hA5);
      send(8'h00);
      exp_evt.push_back(EV_LEN);
      send(8'hA5);
      send(8'h11);
      send(8'h42);
      wait_drain("t4");

      // 5: backpressure with a full FIFO
      payload_ready = 1'b0;
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
      send_frame(pl, 8'h10, EV_OK);
      send(8'hA5);
      @(negedge clk);
      check("t5_head", {7'd0, payload_valid, payload}, 16'h0101);
      @(posedge clk);
      #1;
      exp_pay.push_back({1'b0, 8'hC1});
      exp_pay.push_back({1'b0, 8'hC2});
      exp_pay.push_back({1'b0, 8'hC3});
      exp_pay.push_back({1'b1, 8'hC4});
      exp_evt.push_back(EV_OK);
      data_in  = 8'h04;
      valid_in = 1'b1;
      @(negedge clk);
      check("t5_ready_full", {15'd0, ready_out}, 16'd0);
      @(posedge clk);
      #1;
      repeat (3) pop_one();
      @(negedge clk);
      check("t5_ready_3pops", {15'd0, ready_out}, 16'd0);
      @(posedge clk);
      #1;
      pop_one();
      @(negedge clk);
      check("t5_ready_4pops", {15'd0, ready_out}, 16'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      data_in  = 8'd0;
      send(8'hC1);
      send(8'hC2);
      send(8'hC3);
      send(8'hC4);
      send(8'h04);
      payload_ready = 1'b1;
      wait_drain("t5");

      // 6: reset mid-frame, then test 1 again
      send(8'hA5);
      send(8'h04);
      send(8'h01);
      send(8'h02);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t6_outs", {6'd0, payload_valid, payload_last, payload}, 16'd0);
      check("t6_flags", {12'd0, frame_ok, frame_err, err_code}, 16'd0);
      check("t6_ready", {15'd0, ready_out}, 16'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(pl, 8'h00, EV_OK);
      wait_drain("t6");

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
